// File: rtl/dp_pkg.sv
// Shared datapath definitions: widths, zero-register index, ALU select codes, flag bundle.
package dp_pkg;

  localparam int DATA_W   = 64;
  localparam int ADDR_W   = 5;
  localparam int ZR_INDEX = 31;

  typedef enum logic [2:0] {
    ADD = 3'b000,
    SUB = 3'b001,
    MUL = 3'b010,
    DIV = 3'b011,
    AND = 3'b100,
    OR  = 3'b101
  } alu_sel_e;

  typedef struct packed {
    logic z;
    logic o;
  } flags_t;

endpackage

// File: rtl/flag_reg.sv
// Two-bit condition-flag register: loads on en_i, holds otherwise, async active-low clear.
module flag_reg
  import dp_pkg::flags_t;
(
  input  logic   clk,
  input  logic   rst_n,
  input  logic   en_i,
  input  flags_t d_i,
  output flags_t q_o
);

  flags_t flags_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flags_q <= '0;
    end else if (en_i) begin
      flags_q <= d_i;
    end
  end

  assign q_o = flags_q;

endmodule

// File: rtl/reg_file.sv
// Register file feeding the ALU: two operand read ports, one debug port, one write port,
// hardwired zero register, optional same-cycle write forwarding, and the ALU flag latch.
module reg_file
  import dp_pkg::flags_t;
#(
  parameter int DATA_W   = dp_pkg::DATA_W,
  parameter int ADDR_W   = dp_pkg::ADDR_W,
  parameter int ZR_INDEX = dp_pkg::ZR_INDEX,
  parameter int BYPASS   = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] rd_addr1,
  output logic [DATA_W-1:0] rd_data1,
  input  logic [ADDR_W-1:0] rd_addr2,
  output logic [DATA_W-1:0] rd_data2,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              flag_we,
  input  logic              z_in,
  input  logic              o_in,
  output logic              z_flag,
  output logic              o_flag,
  input  logic [ADDR_W-1:0] dbg_addr,
  output logic [DATA_W-1:0] dbg_data
);

  localparam int                DEPTH = 2 ** ADDR_W;
  localparam logic [ADDR_W-1:0] ZR_A  = ADDR_W'(ZR_INDEX);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic              wr_ok;
  logic              fwd_en;
  logic [ADDR_W-1:0] rd_addr [2];
  logic [DATA_W-1:0] rd_d    [2];
  flags_t            flags_d;
  flags_t            flags_q;

  assign wr_ok = wr_en && (wr_addr != ZR_A);

  // Forwarding is gated by rst_n so reads stay 0 for the whole reset window.
  assign fwd_en = (BYPASS != 0) && rst_n && wr_ok;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else if (wr_ok) begin
      mem_q[wr_addr] <= wr_data;
    end
  end

  assign rd_addr[0] = rd_addr1;
  assign rd_addr[1] = rd_addr2;

  always_comb begin
    for (int p = 0; p < 2; p++) begin
      rd_d[p] = mem_q[rd_addr[p]];
      if (rd_addr[p] == ZR_A) begin
        rd_d[p] = '0;
      end else if (fwd_en && (wr_addr == rd_addr[p])) begin
        rd_d[p] = wr_data;
      end
    end
  end

  assign rd_data1 = rd_d[0];
  assign rd_data2 = rd_d[1];
  assign dbg_data = (dbg_addr == ZR_A) ? '0 : mem_q[dbg_addr];

  assign flags_d.z = z_in;
  assign flags_d.o = o_in;

  flag_reg u_flag_reg (
    .clk   (clk),
    .rst_n (rst_n),
    .en_i  (flag_we),
    .d_i   (flags_d),
    .q_o   (flags_q)
  );

  assign z_flag = flags_q.z;
  assign o_flag = flags_q.o;

endmodule

// File: doc/reg_file.md
Name: reg_file

Overview:
- 32-entry x 64-bit register file that sits directly upstream of the ALU in the single-cycle datapath.
- Two read ports drive ALU operands a and b; one write port takes the ALU result back.
- Also holds a 2-bit condition-flag register that latches the ALU z_f/o_f outputs for later branch use.
- Register ZR_INDEX is the hardwired zero register.

Parameters:
- DATA_W, 64, register and port data width (matches ALU a/b/result).
- ADDR_W, 5, register index width; depth = 2**ADDR_W.
- ZR_INDEX, 31, index of hardwired zero register.
- BYPASS, 1, 1 = same-cycle write-to-read forwarding enabled; 0 = reads return stored value only.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- rd_addr1  input  ADDR_W  read port 1 index.
- rd_data1  output  DATA_W  read port 1 data (to ALU a).
- rd_addr2  input  ADDR_W  read port 2 index.
- rd_data2  output  DATA_W  read port 2 data (to ALU b).
- wr_en  input  1  write enable.
- wr_addr  input  ADDR_W  write index.
- wr_data  input  DATA_W  write data (from ALU result).
- flag_we  input  1  latch flags this cycle.
- z_in  input  1  zero flag from ALU z_f.
- o_in  input  1  overflow flag from ALU o_f.
- z_flag  output  1  registered zero flag.
- o_flag  output  1  registered overflow flag.
- dbg_addr  input  ADDR_W  debug/bench read index.
- dbg_data  output  DATA_W  debug read data; never bypassed.

Behaviour:
- Clocking and reset:
  - One clock domain, clk; reset is asynchronous active-low on rst_n.
  - rst_n low clears all 32 registers, z_flag and o_flag to 0 immediately, independent of clk.
  - rd_data1/2 and dbg_data therefore read 0 during reset for any address (bypass is suppressed while rst_n is low).
  - rst_n deasserts synchronously to the design; the first write is accepted on the first rising edge with rst_n high.
- Write:
  - On a rising edge with wr_en=1 and wr_addr != ZR_INDEX, mem[wr_addr] <= wr_data.
  - Writes to ZR_INDEX are silently dropped; storage is never modified.
- Read:
  - All three read ports are combinational (zero latency).
  - Address ZR_INDEX always returns 0, regardless of bypass or any write.
- Bypass (BYPASS=1):
  - If wr_en=1, wr_addr==rd_addrN and wr_addr != ZR_INDEX, then rd_dataN = wr_data in the same cycle.
  - Each port is evaluated independently.
  - Both ports may forward simultaneously when both addresses match.
  - BYPASS=0: rd_dataN shows the old value until after the edge.
- Flags:
  - On a rising edge with flag_we=1, z_flag <= z_in and o_flag <= o_in.
  - Otherwise flags hold.
  - flag_we and wr_en are independent; both may be active in the same cycle.
- Reset mid-operation: an asserted rst_n overrides any write or flag update in the same cycle; the write is lost.
- Address width: all addresses fully decoded; no out-of-range case with depth = 2**ADDR_W.
- No X propagation:
  - Unwritten registers read 0 (guaranteed by reset).
  - Bench must drive wr_en to a known value.

Decomposition:
- Shared package dp_pkg holds:
  - DATA_W, ADDR_W, ZR_INDEX;
  - the ALU select codes: ADD=3'b000, SUB=3'b001, MUL=3'b010, DIV=3'b011, AND=3'b100, OR=3'b101;
  - a flags typedef {z, o}.
- One natural sub-module: flag_reg (2-bit enable register with async active-low clear), instantiated once.
- Storage array and read/bypass muxing stay in reg_file.

Test Plan:
- Reset: pulse rst_n low mid-cycle after writing mem[3]=64'h1234 -> dbg_data for addr 3 reads 0 immediately; z_flag=o_flag=0 before the next clk edge.
- Write/read: write mem[5]=6 and mem[6]=3 on consecutive edges; set rd_addr1=5, rd_addr2=6 -> rd_data1=6, rd_data2=3. Feed to ALU with sel=000 and write the result to reg 7 -> dbg_data(7)=9.
- Zero register: wr_en=1, wr_addr=31, wr_data=64'hffffffffffffffff -> rd_data1(addr 31)=0 in that cycle and after the edge; dbg_data(31)=0.
- Bypass: BYPASS=1, wr_en=1, wr_addr=rd_addr1=rd_addr2=9, wr_data=64'h7000000000000000 -> both read ports show 64'h7000000000000000 before the edge. With BYPASS=0, both show the prior value (0) until the edge.
- Flags: flag_we=1, z_in=1, o_in=0 -> z_flag=1, o_flag=0 after the edge. Next cycle flag_we=0, z_in=0, o_in=1 -> flags hold at 1/0. Then flag_we=1 with 64'h7000000000000000 + 64'h7000000000000000 through the ALU -> o_flag=1, z_flag=0.
- Reset vs write collision: rst_n low while wr_en=1, wr_addr=2, wr_data=64'haaaa across a clk edge -> mem[2]=0 after rst_n rises.
